// File: rtl/mem_bridge_initiator.sv
// Single-request initiator for the MainMemory3232 bridge: setup/strobe/hold phasing, owns MEMDATA drive.
// Latency accept->rsp_valid = SETUP+STROBE+HOLD+1; req_ready only in IDLE (one request in flight).
module mem_bridge_initiator #(
    parameter int unsigned SETUP_CYCLES    = 1,
    parameter int unsigned STROBE_CYCLES   = 1,
    parameter int unsigned HOLD_CYCLES     = 1,
    parameter bit          ROM_WRITE_BLOCK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] Addr,
    inout  wire  [7:0]  MEMDATA,
    output logic        MemBridge_Load,
    output logic        MemBridge_Direction
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        write_q, write_d;
    logic        blocked_q, blocked_d;
    logic        drive_q, drive_d;
    logic        load_n_q, load_n_d;
    logic        dir_q, dir_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        accept;
    logic        phase_last;

    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            SETUP:   phase_last = (cnt_q == SETUP_LAST);
            STROBE:  phase_last = (cnt_q == STROBE_LAST);
            HOLD:    phase_last = (cnt_q == HOLD_LAST);
            default: phase_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        blocked_d = blocked_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SETUP;
                    cnt_d     = 4'd0;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    write_d   = req_write;
                    blocked_d = ROM_WRITE_BLOCK && req_write && !req_addr[15];
                end
            end
            SETUP: begin
                state_d = phase_last ? STROBE : SETUP;
                cnt_d   = phase_last ? 4'd0 : cnt_q + 4'd1;
            end
            STROBE: begin
                state_d = phase_last ? HOLD : STROBE;
                cnt_d   = phase_last ? 4'd0 : cnt_q + 4'd1;
                // Read data is captured on the edge that closes the strobe window.
                if (phase_last && !write_q) begin
                    rdata_d = MEMDATA;
                end
            end
            HOLD: begin
                state_d = phase_last ? IDLE : HOLD;
                cnt_d   = phase_last ? 4'd0 : cnt_q + 4'd1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Bus controls are decoded from the next state and registered, so they are glitch-free
        // and line up exactly with the phase they belong to.
        dir_d       = !write_d && ((state_d == SETUP) || (state_d == STROBE));
        drive_d     = write_d && !blocked_d && (state_d != IDLE);
        load_n_d    = !(write_d && !blocked_d && (state_d == STROBE));
        rsp_valid_d = (state_q == HOLD) && phase_last;
        rsp_err_d   = rsp_valid_d && blocked_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= 16'd0;
            wdata_q     <= 8'd0;
            rdata_q     <= 8'd0;
            write_q     <= 1'b0;
            blocked_q   <= 1'b0;
            drive_q     <= 1'b0;
            load_n_q    <= 1'b1;
            dir_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            blocked_q   <= blocked_d;
            drive_q     <= drive_d;
            load_n_q    <= load_n_d;
            dir_q       <= dir_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign MEMDATA             = drive_q ? wdata_q : 8'bz;
    assign Addr                = addr_q;
    assign MemBridge_Load      = load_n_q;
    assign MemBridge_Direction = dir_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rdata_q;
    assign rsp_err             = rsp_err_q;

endmodule

// File: tb/tb_mem_bridge_initiator.sv
// Bench for mem_bridge_initiator: default-timing instance u0 and slow-timing instance u1 (2/3/2),
// each attached to a behavioural MainMemory3232 (function ROM, writable RAM on Load low).
module tb_mem_bridge_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [15:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        rsp_err   [2];
    logic [15:0] addr      [2];
    logic        load      [2];
    logic        dir       [2];
    wire  [7:0]  md0, md1;

    logic [7:0]  ram0 [32768];
    logic [7:0]  ram1 [32768];
    logic [7:0]  sh [logic [15:0]];
    int          compared   = 0;
    int          mismatched = 0;
    int          overlap_err = 0;

    always #5 clk = ~clk;

    mem_bridge_initiator u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .Addr(addr[0]), .MEMDATA(md0), .MemBridge_Load(load[0]), .MemBridge_Direction(dir[0])
    );

    mem_bridge_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .Addr(addr[1]), .MEMDATA(md1), .MemBridge_Load(load[1]), .MemBridge_Direction(dir[1])
    );

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] bus_val(input int u);
        logic [15:0] a;
        a = addr[u];
        if (!a[15]) return rom_val(a);
        return (u == 0) ? ram0[a[14:0]] : ram1[a[14:0]];
    endfunction

    function automatic logic [7:0] md_of(input int u);
        return (u == 0) ? md0 : md1;
    endfunction

    // Memory side: drives the bus only while the bridge points Direction at memory.
    assign md0 = dir[0] ? bus_val(0) : 8'bz;
    assign md1 = dir[1] ? bus_val(1) : 8'bz;

    always @(posedge clk) begin
        if (!load[0] && addr[0][15]) ram0[addr[0][14:0]] <= md0;
    end
    always @(posedge clk) begin
        if (!load[1] && addr[1][15]) ram1[addr[1][14:0]] <= md1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                if (dir[u] && !load[u]) overlap_err++;
                if (dir[u] && (md_of(u) !== bus_val(u))) overlap_err++;
            end
        end
    end

    // Reference model: ROM fixed, RAM holds the last value written by an accepted RAM write.
    function automatic logic [7:0] model_read(input logic [15:0] a);
        if (!a[15]) return rom_val(a);
        return sh.exists(a) ? sh[a] : 8'h00;
    endfunction

    function automatic int exp_lat(input int u);
        return (u == 0) ? (1 + 1 + 1 + 1) : (2 + 3 + 2 + 1);
    endfunction

    task automatic do_txn(input int u, input logic wr, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output logic er, output int lat,
                          output int n_load, output int n_dir, output int n_bus);
        int w;
        w = 0;
        while (!req_ready[u] && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        req_valid[u] = 1'b1; req_write[u] = wr; req_addr[u] = a; req_wdata[u] = d;
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        if (wr && a[15]) sh[a] = d;
        rd = 8'h00; er = 1'b0; lat = 0; n_load = 0; n_dir = 0; n_bus = 0;
        for (int i = 1; i <= 60; i++) begin
            if (!load[u]) n_load++;
            if (dir[u]) n_dir++;
            if (wr && (md_of(u) === d)) n_bus++;
            if (rsp_valid[u]) begin
                lat = i; rd = rsp_rdata[u]; er = rsp_err[u];
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) req_valid[u] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            compared++; if (req_ready[u] !== 1'b0) begin mismatched++; $display("FAIL reset_ready u%0d got %b want 0", u, req_ready[u]); end
            compared++; if (rsp_valid[u] !== 1'b0) begin mismatched++; $display("FAIL reset_rsp_valid u%0d got %b want 0", u, rsp_valid[u]); end
            compared++; if (rsp_rdata[u] !== 8'h00) begin mismatched++; $display("FAIL reset_rdata u%0d got %h want 00", u, rsp_rdata[u]); end
            compared++; if (rsp_err[u] !== 1'b0) begin mismatched++; $display("FAIL reset_err u%0d got %b want 0", u, rsp_err[u]); end
            compared++; if (addr[u] !== 16'h0000) begin mismatched++; $display("FAIL reset_addr u%0d got %h want 0000", u, addr[u]); end
            compared++; if (load[u] !== 1'b1) begin mismatched++; $display("FAIL reset_load u%0d got %b want 1", u, load[u]); end
            compared++; if (dir[u] !== 1'b0) begin mismatched++; $display("FAIL reset_dir u%0d got %b want 0", u, dir[u]); end
        end
        reset = 1'b0;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            compared++; if (req_ready[u] !== 1'b1) begin mismatched++; $display("FAIL ready_after_reset u%0d got %b want 1", u, req_ready[u]); end
        end
    endtask

    task automatic test_rom_read;
        logic [7:0] rd; logic er; int lat, nl, nd, nb;
        do_txn(0, 1'b0, 16'h0003, 8'h00, rd, er, lat, nl, nd, nb);
        compared++; if (lat != exp_lat(0)) begin mismatched++; $display("FAIL rom_read_latency got %0d want %0d", lat, exp_lat(0)); end
        compared++; if (nd != 2) begin mismatched++; $display("FAIL rom_read_dir_cycles got %0d want 2", nd); end
        compared++; if (rd !== model_read(16'h0003)) begin mismatched++; $display("FAIL rom_read_data got %h want %h", rd, model_read(16'h0003)); end
        compared++; if ({er, nl[0]} !== 2'b00) begin mismatched++; $display("FAIL rom_read_err_load got err=%b loads=%0d want 0/0", er, nl); end
    endtask

    task automatic test_ram_write_read;
        logic [7:0] rd; logic er; int lat, nl, nd, nb;
        do_txn(0, 1'b1, 16'h8001, 8'hA5, rd, er, lat, nl, nd, nb);
        compared++; if (nl != 1) begin mismatched++; $display("FAIL ram_write_load_cycles got %0d want 1", nl); end
        compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL ram_write_err got %b want 0", er); end
        compared++; if (nb != 3) begin mismatched++; $display("FAIL ram_write_drive_cycles got %0d want 3", nb); end
        compared++; if (nd != 0) begin mismatched++; $display("FAIL ram_write_dir got %0d want 0", nd); end
        do_txn(0, 1'b0, 16'h8001, 8'h00, rd, er, lat, nl, nd, nb);
        compared++; if (rd !== model_read(16'h8001)) begin mismatched++; $display("FAIL ram_readback got %h want %h", rd, model_read(16'h8001)); end
        compared++; if (lat != exp_lat(0)) begin mismatched++; $display("FAIL ram_read_latency got %0d want %0d", lat, exp_lat(0)); end
        @(posedge clk); #1;
        compared++; if (addr[0] !== 16'h8001) begin mismatched++; $display("FAIL addr_hold_idle got %h want 8001", addr[0]); end
    endtask

    task automatic test_rom_write_block;
        logic [7:0] rd; logic er; int lat, nl, nd, nb;
        do_txn(0, 1'b1, 16'h0010, 8'h5A, rd, er, lat, nl, nd, nb);
        compared++; if (nl != 0) begin mismatched++; $display("FAIL rom_write_load got %0d low cycles want 0", nl); end
        compared++; if (nb != 0) begin mismatched++; $display("FAIL rom_write_bus_driven got %0d cycles want 0", nb); end
        compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL rom_write_err got %b want 1", er); end
        compared++; if (lat != exp_lat(0)) begin mismatched++; $display("FAIL rom_write_latency got %0d want %0d", lat, exp_lat(0)); end
        do_txn(0, 1'b0, 16'h0010, 8'h00, rd, er, lat, nl, nd, nb);
        compared++; if (rd !== model_read(16'h0010)) begin mismatched++; $display("FAIL rom_unchanged got %h want %h", rd, model_read(16'h0010)); end
        compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL rom_read_err got %b want 0", er); end
    endtask

    task automatic test_slow_timing;
        logic [7:0] rd, d; logic er; int lat, nl, nd, nb;
        logic [15:0] a;
        for (int k = 0; k < 3; k++) begin
            a = 16'h8000 | 16'($urandom_range(16'h0000, 16'h7FFF));
            d = 8'($urandom_range(1, 254));
            do_txn(1, 1'b1, a, d, rd, er, lat, nl, nd, nb);
            compared++; if (nl != 3) begin mismatched++; $display("FAIL slow_write_load got %0d want 3", nl); end
            compared++; if (lat != exp_lat(1)) begin mismatched++; $display("FAIL slow_write_latency got %0d want %0d", lat, exp_lat(1)); end
            compared++; if (nb != 7) begin mismatched++; $display("FAIL slow_write_drive got %0d want 7", nb); end
            do_txn(1, 1'b0, a, 8'h00, rd, er, lat, nl, nd, nb);
            compared++; if (rd !== model_read(a)) begin mismatched++; $display("FAIL slow_readback addr %h got %h want %h", a, rd, model_read(a)); end
            compared++; if (lat != exp_lat(1)) begin mismatched++; $display("FAIL slow_read_latency got %0d want %0d", lat, exp_lat(1)); end
            compared++; if (nd != 5) begin mismatched++; $display("FAIL slow_read_dir got %0d want 5", nd); end
        end
    endtask

    task automatic test_reset_mid;
        int w, seen;
        while (!req_ready[0]) begin @(posedge clk); #1; end
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h8002; req_wdata[0] = 8'hC3;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        w = 0;
        while (load[0] && w < 20) begin @(posedge clk); #1; w++; end
        compared++; if (load[0] !== 1'b0) begin mismatched++; $display("FAIL mid_strobe_reached load=%b want 0", load[0]); end
        reset = 1'b1;
        @(posedge clk); #1;
        compared++; if (load[0] !== 1'b1) begin mismatched++; $display("FAIL mid_reset_load got %b want 1", load[0]); end
        compared++; if (md0 === 8'hC3) begin mismatched++; $display("FAIL mid_reset_bus still driven %h want released", md0); end
        compared++; if (rsp_valid[0] !== 1'b0) begin mismatched++; $display("FAIL mid_reset_rsp got %b want 0", rsp_valid[0]); end
        reset = 1'b0;
        @(posedge clk); #1;
        compared++; if (req_ready[0] !== 1'b1) begin mismatched++; $display("FAIL mid_reset_ready got %b want 1", req_ready[0]); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid[0]) seen++;
            @(posedge clk); #1;
        end
        compared++; if (seen != 0) begin mismatched++; $display("FAIL mid_reset_no_rsp got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back;
        logic        wr_q [10];
        logic [15:0] a_q  [10];
        logic [7:0]  d_q  [10];
        logic [7:0]  exp_q [10];
        int          acc_cyc [$];
        logic [7:0]  rsp_q [$];
        int          k, cyc;
        logic        acc;
        for (int i = 0; i < 5; i++) begin
            a_q[i] = 16'h8100 + 16'(i * 16) + 16'($urandom_range(0, 15));
            d_q[i] = 8'($urandom_range(0, 255));
            wr_q[i] = 1'b1;
            a_q[i + 5] = a_q[i]; d_q[i + 5] = 8'h00; wr_q[i + 5] = 1'b0;
        end
        for (int i = 0; i < 10; i++) begin
            if (wr_q[i]) sh[a_q[i]] = d_q[i];
            exp_q[i] = model_read(a_q[i]);
        end
        k = 0; cyc = 0;
        req_valid[0] = 1'b1; req_write[0] = wr_q[0]; req_addr[0] = a_q[0]; req_wdata[0] = d_q[0];
        while (rsp_q.size() < 10 && cyc < 200) begin
            acc = req_valid[0] && req_ready[0];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                acc_cyc.push_back(cyc);
                k++;
                if (k < 10) begin
                    req_write[0] = wr_q[k]; req_addr[0] = a_q[k]; req_wdata[0] = d_q[k];
                end else begin
                    req_valid[0] = 1'b0;
                end
            end
            if (rsp_valid[0]) rsp_q.push_back(rsp_rdata[0]);
        end
        req_valid[0] = 1'b0;
        compared++;
        if (rsp_q.size() != 10 || acc_cyc.size() != 10) begin
            mismatched++;
            $display("FAIL b2b_count got %0d rsp %0d acc want 10/10", rsp_q.size(), acc_cyc.size());
        end else begin
            for (int i = 1; i < 10; i++) begin
                compared++;
                if (acc_cyc[i] - acc_cyc[i - 1] != 4) begin
                    mismatched++;
                    $display("FAIL b2b_spacing #%0d got %0d want 4", i, acc_cyc[i] - acc_cyc[i - 1]);
                end
            end
            for (int i = 5; i < 10; i++) begin
                compared++;
                if (rsp_q[i] !== exp_q[i]) begin
                    mismatched++;
                    $display("FAIL b2b_read addr %h got %h want %h", a_q[i], rsp_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 16'h0; req_wdata[u] = 8'h0;
        end
        test_reset();
        test_rom_read();
        test_ram_write_read();
        test_rom_write_block();
        test_slow_timing();
        test_reset_mid();
        test_back_to_back();
        compared++;
        if (overlap_err != 0) begin
            mismatched++;
            $display("FAIL bus_overlap got %0d violating cycles want 0", overlap_err);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
